// File: rtl/mips_mc_pkg.sv
// Shared opcode/funct constants, FSM and ALU enums, and the instruction decoder.
// MIPS_MC_SHIFT_EN enables sll/srl decode; otherwise those functs decode as NOP.
package mips_mc_pkg;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpAndi  = 6'h0c;
  localparam logic [5:0] OpOri   = 6'h0d;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2b;

  localparam logic [5:0] FnSll = 6'h00;
  localparam logic [5:0] FnSrl = 6'h02;
  localparam logic [5:0] FnJr  = 6'h08;
  localparam logic [5:0] FnAdd = 6'h20;
  localparam logic [5:0] FnSub = 6'h22;
  localparam logic [5:0] FnAnd = 6'h24;
  localparam logic [5:0] FnOr  = 6'h25;
  localparam logic [5:0] FnXor = 6'h26;
  localparam logic [5:0] FnSlt = 6'h2a;

  typedef enum logic [2:0] {
    StFetch, StDecode, StExec, StMemwb, StLwwb, StHalt
  } state_e;

  typedef enum logic [2:0] {
    AluAdd, AluSub, AluAnd, AluOr, AluXor, AluSlt, AluSll, AluSrl
  } alu_op_e;

  typedef enum logic [2:0] {
    InNop, InAlu, InLw, InSw, InBeq, InBne, InJr, InJ
  } instr_e;

  typedef struct packed {
    instr_e  kind;
    alu_op_e op;
    logic    use_imm;
    logic    zero_ext;
    logic    wr_rt;
  } dec_t;

  localparam dec_t DecNop = '{kind: InNop, op: AluAdd, use_imm: 1'b0, zero_ext: 1'b0,
                              wr_rt: 1'b0};

  function automatic dec_t decode_instr(input logic [5:0] opcode, input logic [5:0] funct);
    dec_t d;
    d = DecNop;
    case (opcode)
      OpRtype: begin
        case (funct)
          FnAdd: begin d.kind = InAlu; d.op = AluAdd; end
          FnSub: begin d.kind = InAlu; d.op = AluSub; end
          FnAnd: begin d.kind = InAlu; d.op = AluAnd; end
          FnOr:  begin d.kind = InAlu; d.op = AluOr;  end
          FnXor: begin d.kind = InAlu; d.op = AluXor; end
          FnSlt: begin d.kind = InAlu; d.op = AluSlt; end
          FnJr:  d.kind = InJr;
`ifdef MIPS_MC_SHIFT_EN
          FnSll: begin d.kind = InAlu; d.op = AluSll; end
          FnSrl: begin d.kind = InAlu; d.op = AluSrl; end
`else
          FnSll, FnSrl: d.kind = InNop;
`endif
          default: d.kind = InNop;
        endcase
      end
      OpJ:    d.kind = InJ;
      OpBeq:  d.kind = InBeq;
      OpBne:  d.kind = InBne;
      OpAddi: begin d.kind = InAlu; d.op = AluAdd; d.use_imm = 1'b1; d.wr_rt = 1'b1; end
      OpAndi: begin
        d.kind = InAlu; d.op = AluAnd; d.use_imm = 1'b1; d.zero_ext = 1'b1; d.wr_rt = 1'b1;
      end
      OpOri: begin
        d.kind = InAlu; d.op = AluOr; d.use_imm = 1'b1; d.zero_ext = 1'b1; d.wr_rt = 1'b1;
      end
      OpLw:   begin d.kind = InLw; d.op = AluAdd; d.use_imm = 1'b1; d.wr_rt = 1'b1; end
      OpSw:   begin d.kind = InSw; d.op = AluAdd; d.use_imm = 1'b1; end
      default: d.kind = InNop;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mips_mc_if.sv
// Split-bus memory port: core is master, memory is slave.
interface mips_mc_if #(
  parameter int unsigned ADDR_W = 7
) ();
  logic              cs;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;

  modport master (output cs, output we, output addr, output wdata, input rdata);
  modport slave  (input cs, input we, input addr, input wdata, output rdata);
endinterface

// File: rtl/mips_mc_regfile.sv
// 32x32 register file: two combinational reads, one synchronous write, $0 hardwired.
module mips_mc_regfile
  import mips_mc_pkg::*;
#(
  parameter int unsigned TAP_REG = 1,
  parameter int unsigned TAP_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       raddr_a,
  input  logic [4:0]       raddr_b,
  output logic [31:0]      rdata_a,
  output logic [31:0]      rdata_b,
  input  logic             we,
  input  logic [4:0]       waddr,
  input  logic [31:0]      wdata,
  output logic [TAP_W-1:0] tap
);

  logic [31:0] regs_q [0:31];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (we && (waddr != 5'd0)) begin
      regs_q[waddr] <= wdata;
    end
  end

  assign rdata_a = (raddr_a == 5'd0) ? '0 : regs_q[raddr_a];
  assign rdata_b = (raddr_b == 5'd0) ? '0 : regs_q[raddr_b];
  assign tap     = (TAP_REG == 0) ? '0 : regs_q[TAP_REG][TAP_W-1:0];

endmodule

// File: rtl/mips_mc_core.sv
// Multicycle MIPS integer core with HALT handshake and register tap.
// Define MIPS_MC_SHIFT_EN to build the sll/srl shifter.
module mips_mc_core
  import mips_mc_pkg::*;
#(
  parameter int unsigned ADDR_W  = 7,
  parameter int unsigned TAP_REG = 1,
  parameter int unsigned TAP_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             halt,
  output logic             halted,
  output logic [TAP_W-1:0] reg_tap,
  mips_mc_if.master        mem
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q;
  logic [31:0]       ir_q;
  dec_t              dec, dec_q;
  logic [31:0]       a_q, b_q, imm_q, result_q, mdr_q;
  logic [31:0]       rs_val, rt_val, imm_ext, op_b, alu_res;

  logic              cs, we;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              rf_we;
  logic [4:0]        rf_waddr;
  logic [31:0]       rf_wdata;

  assign dec     = decode_instr(ir_q[31:26], ir_q[5:0]);
  assign imm_ext = dec.zero_ext ? {16'h0000, ir_q[15:0]} : {{16{ir_q[15]}}, ir_q[15:0]};

  mips_mc_regfile #(
    .TAP_REG (TAP_REG),
    .TAP_W   (TAP_W)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .raddr_a (ir_q[25:21]),
    .raddr_b (ir_q[20:16]),
    .rdata_a (rs_val),
    .rdata_b (rt_val),
    .we      (rf_we),
    .waddr   (rf_waddr),
    .wdata   (rf_wdata),
    .tap     (reg_tap)
  );

  always_comb begin
    op_b    = dec_q.use_imm ? imm_q : b_q;
    alu_res = '0;
    case (dec_q.op)
      AluAdd: alu_res = a_q + op_b;
      AluSub: alu_res = a_q - op_b;
      AluAnd: alu_res = a_q & op_b;
      AluOr:  alu_res = a_q | op_b;
      AluXor: alu_res = a_q ^ op_b;
      AluSlt: alu_res = {31'b0, ($signed(a_q) < $signed(op_b))};
`ifdef MIPS_MC_SHIFT_EN
      AluSll: alu_res = b_q << ir_q[10:6];
      AluSrl: alu_res = b_q >> ir_q[10:6];
`endif
      default: alu_res = '0;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StFetch;
    else        state_q <= state_d;
  end

  // FSM next state; NOPs still spend an EXEC cycle so every non-jump takes >= 3 cycles
  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch:  state_d = halt ? StHalt : StDecode;
      StDecode: state_d = (dec.kind == InJ) ? StFetch : StExec;
      StExec:   state_d = (dec_q.kind inside {InAlu, InLw, InSw}) ? StMemwb : StFetch;
      StMemwb:  state_d = (dec_q.kind == InLw) ? StLwwb : StFetch;
      StLwwb:   state_d = StFetch;
      StHalt:   state_d = halt ? StHalt : StFetch;
      default:  state_d = StFetch;
    endcase
  end

  // FSM outputs: memory strobes and register-file write port
  always_comb begin
    cs       = 1'b0;
    we       = 1'b0;
    addr     = '0;
    wdata    = '0;
    halted   = 1'b0;
    rf_we    = 1'b0;
    rf_waddr = dec_q.wr_rt ? ir_q[20:16] : ir_q[15:11];
    rf_wdata = result_q;
    case (state_q)
      StFetch: begin
        cs   = !halt;
        addr = pc_q;
      end
      StMemwb: begin
        case (dec_q.kind)
          InSw: begin
            cs    = 1'b1;
            we    = 1'b1;
            addr  = result_q[ADDR_W-1:0];
            wdata = b_q;
          end
          InLw: begin
            cs   = 1'b1;
            addr = result_q[ADDR_W-1:0];
          end
          InAlu:   rf_we = 1'b1;
          default: rf_we = 1'b0;
        endcase
      end
      StLwwb: begin
        rf_we    = 1'b1;
        rf_waddr = ir_q[20:16];
        rf_wdata = mdr_q;
      end
      StHalt:  halted = 1'b1;
      default: halted = 1'b0;
    endcase
    // Reset aborts any access immediately, not at the next edge
    if (!rst_n) begin
      cs = 1'b0;
      we = 1'b0;
    end
  end

  assign mem.cs    = cs;
  assign mem.we    = we;
  assign mem.addr  = addr;
  assign mem.wdata = wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= '0;
      ir_q     <= '0;
      dec_q    <= DecNop;
      a_q      <= '0;
      b_q      <= '0;
      imm_q    <= '0;
      result_q <= '0;
      mdr_q    <= '0;
    end else begin
      case (state_q)
        StFetch: begin
          if (!halt) begin
            ir_q <= mem.rdata;
            pc_q <= pc_q + ADDR_W'(1);
          end
        end
        StDecode: begin
          dec_q <= dec;
          a_q   <= rs_val;
          b_q   <= rt_val;
          imm_q <= imm_ext;
          if (dec.kind == InJ) pc_q <= ir_q[ADDR_W-1:0];
        end
        StExec: begin
          result_q <= alu_res;
          if (((dec_q.kind == InBeq) && (a_q == b_q)) ||
              ((dec_q.kind == InBne) && (a_q != b_q))) begin
            pc_q <= pc_q + imm_q[ADDR_W-1:0];
          end else if (dec_q.kind == InJr) begin
            pc_q <= a_q[ADDR_W-1:0];
          end
        end
        StMemwb: mdr_q <= mem.rdata;
        default: mdr_q <= mdr_q;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_mc_core.sv
// Directed bench for mips_mc_core: one program image, cycle-exact checks of the tap and bus.
module tb_mips_mc_core;

  localparam int unsigned AW = 7;
`ifdef MIPS_MC_SHIFT_EN
  localparam int         ShExtra = 1;
  localparam logic [7:0] SllTap  = 8'h80;
`else
  localparam int         ShExtra = 0;
  localparam logic [7:0] SllTap  = 8'h0a;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       halt = 1'b0;
  logic       halted;
  logic [7:0] reg_tap;
  int         cyc;
  int         tests = 0;
  int         fails = 0;
  int         b, p, q;
  logic [31:0] mem_arr [0:127];

  mips_mc_if #(.ADDR_W(AW)) mem_if ();

  mips_mc_core #(
    .ADDR_W  (AW),
    .TAP_REG (1),
    .TAP_W   (8)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .halt    (halt),
    .halted  (halted),
    .reg_tap (reg_tap),
    .mem     (mem_if)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Memory: registers read data and commits writes on the falling edge
  initial begin
    for (int i = 0; i < 128; i++) mem_arr[i] = 32'h0;
    mem_arr[0]    = 32'h20010006; // addi $1,$0,6
    mem_arr[1]    = 32'h20020012; // addi $2,$0,0x12
    mem_arr[2]    = 32'h00221820; // add  $3,$1,$2
    mem_arr[3]    = 32'hac030020; // sw   $3,0x20($0)
    mem_arr[4]    = 32'h10000002; // beq  $0,$0,+2
    mem_arr[5]    = 32'h20010055; // skipped
    mem_arr[6]    = 32'h20010055; // skipped
    mem_arr[7]    = 32'h14000002; // bne  $0,$0,+2
    mem_arr[8]    = 32'h8c010021; // lw   $1,0x21($0)
    mem_arr[9]    = 32'h20000005; // addi $0,$0,5
    mem_arr[10]   = 32'h00000820; // add  $1,$0,$0
    mem_arr[11]   = 32'h00020822; // sub  $1,$0,$2
    mem_arr[12]   = 32'h0022082a; // slt  $1,$1,$2
    mem_arr[13]   = 32'h3421f0f0; // ori  $1,$1,0xf0f0
    mem_arr[14]   = 32'h0020082a; // slt  $1,$1,$0
    mem_arr[15]   = 32'h00620826; // xor  $1,$3,$2
    mem_arr[16]   = 32'h00030900; // sll  $1,$3,4
    mem_arr[17]   = 32'h0800007f; // j    0x7f
    mem_arr[8'h21] = 32'h00000120;
    mem_arr[8'h7f] = 32'h20010033; // addi $1,$0,0x33
    mem_if.rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (mem_if.cs && !mem_if.we) mem_if.rdata = mem_arr[mem_if.addr];
      else if (mem_if.cs && mem_if.we) mem_arr[mem_if.addr] = mem_if.wdata;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc + 1);
    end
  endtask

  // Lands on the falling edge inside cycle k (cycle 1 = first fetch after reset)
  task automatic at_cycle(input int k);
    do @(negedge clk); while (cyc < k - 1);
  endtask

  task automatic sync_fetch(input logic [AW-1:0] a, input int budget, input string tag,
                            output int at);
    logic found;
    found = 1'b0;
    for (int n = 0; n < budget && !found; n++) begin
      @(negedge clk);
      if (mem_if.cs && !mem_if.we && mem_if.addr == a) found = 1'b1;
    end
    chk(tag, {31'b0, found}, 32'd1);
    at = cyc + 1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs", {31'b0, mem_if.cs}, 32'd0);
    chk("rst_we", {31'b0, mem_if.we}, 32'd0);
    chk("rst_addr", {25'b0, mem_if.addr}, 32'd0);
    chk("rst_wdata", mem_if.wdata, 32'd0);
    chk("rst_halted", {31'b0, halted}, 32'd0);
    chk("rst_tap", {24'b0, reg_tap}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    at_cycle(1);
    chk("fetch0_cs", {31'b0, mem_if.cs}, 32'd1);
    chk("fetch0_addr", {25'b0, mem_if.addr}, 32'd0);
    at_cycle(4);  chk("tap_before_addi", {24'b0, reg_tap}, 32'h00);
    at_cycle(5);  chk("tap_addi", {24'b0, reg_tap}, 32'h06);
    at_cycle(15); chk("sw_exec_no_cs", {31'b0, mem_if.cs}, 32'd0);
    at_cycle(16);
    chk("sw_cs", {31'b0, mem_if.cs}, 32'd1);
    chk("sw_we", {31'b0, mem_if.we}, 32'd1);
    chk("sw_addr", {25'b0, mem_if.addr}, 32'h20);
    chk("sw_wdata", mem_if.wdata, 32'h18);
    at_cycle(17); chk("fetch_beq", {25'b0, mem_if.addr}, 32'd4);
    at_cycle(20); chk("beq_taken", {25'b0, mem_if.addr}, 32'd7);
    at_cycle(23); chk("bne_not_taken", {25'b0, mem_if.addr}, 32'd8);
    at_cycle(26);
    chk("lw_cs", {31'b0, mem_if.cs}, 32'd1);
    chk("lw_we", {31'b0, mem_if.we}, 32'd0);
    chk("lw_addr", {25'b0, mem_if.addr}, 32'h21);
    at_cycle(27); chk("tap_before_lw", {24'b0, reg_tap}, 32'h06);
    at_cycle(28); chk("tap_lw", {24'b0, reg_tap}, 32'h20);
    at_cycle(36); chk("r0_hardwired", {24'b0, reg_tap}, 32'h00);
    at_cycle(40); chk("sub_wrap", {24'b0, reg_tap}, 32'hee);
    at_cycle(44); chk("slt_signed", {24'b0, reg_tap}, 32'h01);
    at_cycle(48); chk("ori", {24'b0, reg_tap}, 32'hf1);
    at_cycle(52); chk("ori_zero_ext", {24'b0, reg_tap}, 32'h00);
    at_cycle(56); chk("xor", {24'b0, reg_tap}, 32'h0a);

    sync_fetch(7'd17, 10, "fetch_j_seen", b);
    chk("sll_cycles", b, 59 + ShExtra);
    chk("sll_result", {24'b0, reg_tap}, {24'b0, SllTap});
    at_cycle(b + 2); chk("j_target", {25'b0, mem_if.addr}, 32'h7f);
    at_cycle(b + 6);
    chk("tap_addi_7f", {24'b0, reg_tap}, 32'h33);
    chk("pc_wrap", {25'b0, mem_if.addr}, 32'd0);
    chk("pc_wrap_cs", {31'b0, mem_if.cs}, 32'd1);
    p = b + 6;

    at_cycle(p + 14);
    halt = 1'b1;
    at_cycle(p + 15);
    chk("halt_sw_we", {31'b0, mem_if.we}, 32'd1);
    chk("halt_sw_addr", {25'b0, mem_if.addr}, 32'h20);
    at_cycle(p + 16);
    chk("halt_boundary_cs", {31'b0, mem_if.cs}, 32'd0);
    chk("halt_boundary_halted", {31'b0, halted}, 32'd0);
    for (int i = 17; i <= 26; i++) begin
      at_cycle(p + i);
      chk("halted", {31'b0, halted}, 32'd1);
      chk("halted_no_cs", {31'b0, mem_if.cs}, 32'd0);
    end
    halt = 1'b0;
    at_cycle(p + 27);
    chk("resume_cs", {31'b0, mem_if.cs}, 32'd1);
    chk("resume_addr", {25'b0, mem_if.addr}, 32'd4);
    chk("resume_halted", {31'b0, halted}, 32'd0);

    sync_fetch(7'd3, 120, "fetch_sw_seen", q);
    at_cycle(q + 3);
    chk("pre_rst_we", {31'b0, mem_if.we}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_cs", {31'b0, mem_if.cs}, 32'd0);
    chk("async_rst_we", {31'b0, mem_if.we}, 32'd0);
    chk("async_rst_addr", {25'b0, mem_if.addr}, 32'd0);
    chk("async_rst_tap", {24'b0, reg_tap}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    at_cycle(1);
    chk("restart_cs", {31'b0, mem_if.cs}, 32'd1);
    chk("restart_addr", {25'b0, mem_if.addr}, 32'd0);
    at_cycle(5);
    chk("restart_tap", {24'b0, reg_tap}, 32'h06);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
